// File: rtl/dds_multi_core.sv
// Multi-channel DDS core: per-channel shadow/active registers, phase accumulator and 3-stage sample pipeline.
// Optional linear FTW sweep is compiled in with `define DDS_SWEEP_EN.
module dds_multi_core #(
    parameter int CH        = 2,
    parameter int PHASE_W   = 32,
    parameter int OUT_W     = 10,
    parameter int LUT_AW    = 8,
    parameter     SINE_FILE = "sine.hex"
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [2:0]            cfg_ch,
    input  logic [2:0]            cfg_addr,
    input  logic [PHASE_W-1:0]    cfg_data,
    output logic [CH*OUT_W-1:0]   wave_data,
    output logic                  wave_valid
);

    localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

    // Sine table is generated at elaboration (Bhaskara approximation) so no init file has to ship with the core.
    function automatic logic [OUT_W-1:0] sine_entry(input int idx);
        longint half, i, amp, num, den, mag;
        half = longint'(1) << (LUT_AW - 1);
        i    = (longint'(idx) >= half) ? longint'(idx) - half : longint'(idx);
        amp  = (longint'(1) << (OUT_W - 1)) - longint'(1);
        num  = longint'(16) * i * (half - i) * amp;
        den  = longint'(5) * half * half - longint'(4) * i * (half - i);
        mag  = (longint'(2) * num + den) / (longint'(2) * den);
        if (longint'(idx) >= half)
            return OUT_W'((longint'(1) << (OUT_W - 1)) - mag);
        else
            return OUT_W'((longint'(1) << (OUT_W - 1)) + mag);
    endfunction

    function automatic logic [OUT_W-1:0] scale_amp(input logic [OUT_W-1:0] v, input logic [1:0] sh);
        logic signed [OUT_W-1:0] s;
        s = $signed(v ^ MID) >>> sh;
        return $unsigned(s) ^ MID;
    endfunction

    logic [OUT_W-1:0] sine_rom_s [2**LUT_AW];
    logic             cfg_ready_q;
    logic [1:0]       fill_q;
    logic             wave_valid_q;
    logic             wr_s;
    logic             ch_ok_s;

    for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
        assign sine_rom_s[i] = sine_entry(i);
    end

    assign wr_s       = cfg_valid && cfg_ready_q;
    assign ch_ok_s    = ({29'd0, cfg_ch} < 32'(CH));
    assign cfg_ready  = cfg_ready_q;
    assign wave_valid = wave_valid_q;

    // Port handshake and pipeline-fill tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_ready_q  <= 1'b1;
            fill_q       <= 2'd0;
            wave_valid_q <= 1'b0;
        end else begin
            cfg_ready_q  <= !(wr_s && ch_ok_s && (cfg_addr == 3'd7));
            fill_q       <= (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
            wave_valid_q <= wave_valid_q || (fill_q == 2'd2);
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic               hit_s, commit_s, clear_s;
        logic [PHASE_W-1:0] ftw_sh_q, pow_sh_q, ftw_act_q, pow_act_q;
        logic [PHASE_W-1:0] acc_q, acc_d, ftw_act_d, ph_q;
        logic [1:0]         mode_sh_q, amp_sh_q, mode_act_q, amp_act_q;
        logic [1:0]         mode1_q, amp1_q, amp2_q;
        logic               en_sh_q, en_act_q, en1_q, en2_q;
        logic [OUT_W-1:0]   v_d, v_q, out_q;
`ifdef DDS_SWEEP_EN
        logic [PHASE_W-1:0] step_sh_q, end_sh_q, step_act_q, end_act_q, ftw_start_q;
        logic               swp_sh_q, swp_act_q;
        logic [PHASE_W:0]   sum_s;
`endif

        assign hit_s    = wr_s && (cfg_ch == 3'(k));
        assign commit_s = hit_s && (cfg_addr == 3'd7);
        assign clear_s  = commit_s && cfg_data[0];

        // Shadow register writes; reserved/absent addresses fall through.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                ftw_sh_q  <= {PHASE_W{1'b0}};
                pow_sh_q  <= {PHASE_W{1'b0}};
                mode_sh_q <= 2'd0;
                amp_sh_q  <= 2'd0;
                en_sh_q   <= 1'b0;
`ifdef DDS_SWEEP_EN
                swp_sh_q  <= 1'b0;
                step_sh_q <= {PHASE_W{1'b0}};
                end_sh_q  <= {PHASE_W{1'b0}};
`endif
            end else if (hit_s) begin
                case (cfg_addr)
                    3'd0: ftw_sh_q  <= cfg_data;
                    3'd1: pow_sh_q  <= cfg_data;
                    3'd2: mode_sh_q <= cfg_data[1:0];
                    3'd3: amp_sh_q  <= cfg_data[1:0];
                    3'd4: begin
                        en_sh_q  <= cfg_data[0];
`ifdef DDS_SWEEP_EN
                        swp_sh_q <= cfg_data[1];
`endif
                    end
`ifdef DDS_SWEEP_EN
                    3'd5: step_sh_q <= cfg_data;
                    3'd6: end_sh_q  <= cfg_data;
`endif
                    default: ;
                endcase
            end
        end

        // Accumulator advances with the FTW active before this edge, so a commit never skews the current step.
        always_comb begin
            if (clear_s)
                acc_d = {PHASE_W{1'b0}};
            else if (en_act_q)
                acc_d = acc_q + ftw_act_q;
            else
                acc_d = acc_q;
        end

`ifdef DDS_SWEEP_EN
        assign sum_s = {1'b0, ftw_act_q} + {1'b0, step_act_q};

        // Sawtooth sweep: reload the committed start FTW on reaching the end value or on carry-out.
        always_comb begin
            if (commit_s)
                ftw_act_d = ftw_sh_q;
            else if (en_act_q && swp_act_q) begin
                if (sum_s[PHASE_W] || (sum_s[PHASE_W-1:0] >= end_act_q))
                    ftw_act_d = ftw_start_q;
                else
                    ftw_act_d = sum_s[PHASE_W-1:0];
            end else
                ftw_act_d = ftw_act_q;
        end
`else
        // Active FTW only moves on commit.
        always_comb begin
            if (commit_s)
                ftw_act_d = ftw_sh_q;
            else
                ftw_act_d = ftw_act_q;
        end
`endif

        // Active registers and accumulator.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                acc_q      <= {PHASE_W{1'b0}};
                ftw_act_q  <= {PHASE_W{1'b0}};
                pow_act_q  <= {PHASE_W{1'b0}};
                mode_act_q <= 2'd0;
                amp_act_q  <= 2'd0;
                en_act_q   <= 1'b0;
`ifdef DDS_SWEEP_EN
                swp_act_q   <= 1'b0;
                step_act_q  <= {PHASE_W{1'b0}};
                end_act_q   <= {PHASE_W{1'b0}};
                ftw_start_q <= {PHASE_W{1'b0}};
`endif
            end else begin
                acc_q     <= acc_d;
                ftw_act_q <= ftw_act_d;
                if (commit_s) begin
                    pow_act_q  <= pow_sh_q;
                    mode_act_q <= mode_sh_q;
                    amp_act_q  <= amp_sh_q;
                    en_act_q   <= en_sh_q;
`ifdef DDS_SWEEP_EN
                    swp_act_q   <= swp_sh_q;
                    step_act_q  <= step_sh_q;
                    end_act_q   <= end_sh_q;
                    ftw_start_q <= ftw_sh_q;
`endif
                end
            end
        end

        // Waveform select from the registered phase.
        always_comb begin
            case (mode1_q)
                2'd0:    v_d = sine_rom_s[ph_q[PHASE_W-1 -: LUT_AW]];
                2'd1:    v_d = ph_q[PHASE_W-1] ? {OUT_W{1'b0}} : {OUT_W{1'b1}};
                2'd2:    v_d = ph_q[PHASE_W-1] ? ~ph_q[PHASE_W-2 -: OUT_W] : ph_q[PHASE_W-2 -: OUT_W];
                2'd3:    v_d = ph_q[PHASE_W-1 -: OUT_W];
                default: v_d = MID;
            endcase
        end

        // Sample pipeline; mode/amp/enable travel with the phase they belong to.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                ph_q    <= {PHASE_W{1'b0}};
                mode1_q <= 2'd0;
                amp1_q  <= 2'd0;
                en1_q   <= 1'b0;
                v_q     <= MID;
                amp2_q  <= 2'd0;
                en2_q   <= 1'b0;
                out_q   <= MID;
            end else begin
                ph_q    <= acc_q + pow_act_q;
                mode1_q <= mode_act_q;
                amp1_q  <= amp_act_q;
                en1_q   <= en_act_q;
                v_q     <= v_d;
                amp2_q  <= amp1_q;
                en2_q   <= en1_q;
                out_q   <= en2_q ? scale_amp(v_q, amp2_q) : MID;
            end
        end

        assign wave_data[k*OUT_W +: OUT_W] = out_q;
    end

endmodule
